// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy (pending writeback) bits.
// Priority per index: flush > alloc > write clear > hold.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_idx,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_idx,
    input  logic              flush,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // NOTE: start from the held value so every bit is assigned on every path; no latches.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w]) begin
                busy_d[wr_idx[w*AW +: AW]] = 1'b0;
            end
        end
        // Alloc is applied after the clears: the new producer is still outstanding.
        if (alloc_en) begin
            busy_d[alloc_idx] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NRD-read / NWR-write register file with optional write-to-read
// bypass, register 0 hardwiring and integrated busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_idx,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_idx,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_idx,
    input  logic                flush,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    logic [AW-1:0]   rd_sel  [NRD];
    logic [AW-1:0]   wr_sel  [NWR];
    logic [XLEN-1:0] wr_word [NWR];
    logic [NWR-1:0]  wr_ok;

    for (genvar p = 0; p < NRD; p++) begin : g_rd_unpack
        assign rd_sel[p] = rd_idx[p*AW +: AW];
    end

    // Writes to register 0 are discarded when it is hardwired.
    for (genvar w = 0; w < NWR; w++) begin : g_wr_unpack
        assign wr_sel[w]  = wr_idx[w*AW +: AW];
        assign wr_word[w] = wr_data[w*XLEN +: XLEN];
        assign wr_ok[w]   = wr_en[w] && !((ZERO_REG != 0) && (wr_sel[w] == '0));
    end

    // Higher-numbered ports are applied last, so they win on a shared index.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        for (int w = 0; w < NWR; w++) begin
            if (wr_ok[w]) begin
                regs_d[wr_sel[w]] = wr_word[w];
            end
        end
    end

    // NOTE: the array is reset because every register must read zero after reset;
    // this deliberately builds it from flops rather than a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_data[p*XLEN +: XLEN] = regs_q[rd_sel[p]];
            rd_busy[p]              = busy_vec[rd_sel[p]];
            if (BYPASS != 0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wr_ok[w] && (wr_sel[w] == rd_sel[p])) begin
                        rd_data[p*XLEN +: XLEN] = wr_word[w];
                        rd_busy[p]              = 1'b0;
                    end
                end
            end
            if ((ZERO_REG != 0) && (rd_sel[p] == '0)) begin
                rd_data[p*XLEN +: XLEN] = '0;
                rd_busy[p]              = 1'b0;
            end
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .alloc_en  (alloc_en),
        .alloc_idx (alloc_idx),
        .flush     (flush),
        .busy_vec  (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one bypassing instance and one non-bypassing
// instance driven from the same stimulus, checked against hand-computed values.
module tb_regfile_mp;
    import regfile_pkg::*;

    localparam int AW = AW_DEF;

    logic           clk = 1'b0;
    logic           rst;
    logic [2*AW-1:0]  rd_idx;
    logic [63:0]      rd_data, rd_data_nb;
    logic [1:0]       rd_busy, rd_busy_nb;
    logic [1:0]       wr_en;
    logic [2*AW-1:0]  wr_idx;
    logic [63:0]      wr_data;
    logic             alloc_en;
    reg_idx_t         alloc_idx;
    logic             flush;
    logic [31:0]      busy_vec, busy_vec_nb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_idx(alloc_idx), .flush(flush), .busy_vec(busy_vec)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_idx(alloc_idx), .flush(flush), .busy_vec(busy_vec_nb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input reg_idx_t idx);
        rd_idx[p*AW +: AW] = idx;
    endtask

    task automatic set_wr(input int w, input reg_idx_t idx, input xword_t data);
        wr_en[w]             = 1'b1;
        wr_idx[w*AW +: AW]   = idx;
        wr_data[w*32 +: 32]  = data;
    endtask

    task automatic idle();
        wr_en    = '0;
        alloc_en = 1'b0;
        flush    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_idx = '0; wr_en = '0; wr_idx = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_idx = '0; flush = 1'b0;

        // 1. reset state on every register and both ports
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            set_rd(0, reg_idx_t'(i));
            set_rd(1, reg_idx_t'(31 - i));
            #1;
            check($sformatf("rst_rd0_r%0d", i), rd_data[31:0], 32'h0);
            check($sformatf("rst_rd1_r%0d", 31 - i), rd_data[63:32], 32'h0);
            check($sformatf("rst_busy_r%0d", i), {30'b0, rd_busy}, 32'h0);
        end
        check("rst_busy_vec", busy_vec, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_busy_vec", busy_vec, 32'h0);

        // 2. basic write and hardwired zero
        set_wr(0, 5'd5, 32'hDEADBEEF);
        set_wr(1, 5'd0, 32'h12345678);
        set_rd(1, 5'd0);
        #1;
        check("x0_no_bypass", rd_data[63:32], 32'h0);
        tick();
        idle();
        set_rd(0, 5'd5);
        set_rd(1, 5'd0);
        #1;
        check("r5_stored", rd_data[31:0], 32'hDEADBEEF);
        check("r0_zero", rd_data[63:32], 32'h0);
        check("r5_stored_nb", rd_data_nb[31:0], 32'hDEADBEEF);

        // 3. bypass and write-port priority
        set_wr(0, 5'd7, 32'h1);
        set_wr(1, 5'd7, 32'h2);
        set_rd(0, 5'd7);
        #1;
        check("r7_bypass", rd_data[31:0], 32'h2);
        check("r7_bypass_busy", {31'b0, rd_busy[0]}, 32'h0);
        check("r7_nb_old", rd_data_nb[31:0], 32'h0);
        tick();
        idle();
        #1;
        check("r7_stored", rd_data[31:0], 32'h2);
        check("r7_stored_nb", rd_data_nb[31:0], 32'h2);

        // 4. scoreboard alloc / clear / alloc-beats-write
        alloc_en = 1'b1; alloc_idx = 5'd9;
        tick();
        idle();
        set_rd(0, 5'd9);
        #1;
        check("r9_busy_vec", busy_vec, 32'h0000_0200);
        check("r9_rd_busy", {31'b0, rd_busy[0]}, 32'h1);
        set_wr(0, 5'd9, 32'hA5);
        #1;
        check("r9_wr_bypass_busy", {31'b0, rd_busy[0]}, 32'h0);
        check("r9_wr_nb_busy", {31'b0, rd_busy_nb[0]}, 32'h1);
        tick();
        idle();
        #1;
        check("r9_cleared", busy_vec, 32'h0);
        check("r9_data", rd_data[31:0], 32'hA5);
        alloc_en = 1'b1; alloc_idx = 5'd9;
        set_wr(0, 5'd9, 32'hB6);
        tick();
        idle();
        #1;
        check("r9_alloc_wins", busy_vec, 32'h0000_0200);
        check("r9_data2", rd_data[31:0], 32'hB6);
        check("r9_rd_busy2", {31'b0, rd_busy[0]}, 32'h1);
        alloc_en = 1'b1; alloc_idx = 5'd0;
        tick();
        idle();
        set_rd(1, 5'd0);
        #1;
        check("r0_alloc_ignored", busy_vec, 32'h0000_0200);
        check("r0_rd_busy", {31'b0, rd_busy[1]}, 32'h0);

        // 5. flush beats alloc, write in flush cycle still commits
        alloc_en = 1'b1; alloc_idx = 5'd3;  tick();
        alloc_idx = 5'd4;                   tick();
        alloc_idx = 5'd10;                  tick();
        idle();
        #1;
        check("pre_flush_busy", busy_vec, 32'h0000_0618);
        flush = 1'b1;
        alloc_en = 1'b1; alloc_idx = 5'd11;
        set_wr(1, 5'd4, 32'h55);
        tick();
        idle();
        set_rd(0, 5'd4);
        #1;
        check("flush_busy_vec", busy_vec, 32'h0);
        check("flush_busy_vec_nb", busy_vec_nb, 32'h0);
        check("flush_r4_data", rd_data[31:0], 32'h55);

        // 6. asynchronous reset between edges
        set_wr(0, 5'd12, 32'hFF);
        alloc_en = 1'b1; alloc_idx = 5'd13;
        tick();
        idle();
        set_rd(0, 5'd12);
        #1;
        check("r12_before_rst", rd_data[31:0], 32'hFF);
        check("r13_busy_before_rst", busy_vec, 32'h0000_2000);
        set_wr(1, 5'd14, 32'h77);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_r12", rd_data[31:0], 32'h0);
        check("async_rst_busy_vec", busy_vec, 32'h0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        set_rd(1, 5'd14);
        #1;
        check("r14_lost", rd_data[63:32], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file with integer-pipeline scoreboard; successor to the fixed 2R1W 32x32 register file.
- Configurable width, depth, read-port count and write-port count.
- Optional write-to-read bypass.
- Per-register busy (pending-writeback) tracking so decode can stall on RAW hazards without a separate scoreboard.
- Sits between decode (reads, allocates destinations) and writeback (multiple result ports, e.g. ALU + LSU).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of registers; power of two, >= 2.
- NRD, 2, number of read ports, 1..4.
- NWR, 2, number of write ports, 1..2.
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.
- Derived localparam AW = $clog2(NREGS).

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- rd_idx, input, NRD*AW, packed read addresses; port p at [p*AW +: AW].
- rd_data, output, NRD*XLEN, packed read data; combinational.
- rd_busy, output, NRD, per-port busy flag of the addressed register; combinational.
- wr_en, input, NWR, per-port write enable.
- wr_idx, input, NWR*AW, packed write addresses.
- wr_data, input, NWR*XLEN, packed write data.
- alloc_en, input, 1, mark alloc_idx busy (destination issued).
- alloc_idx, input, AW, register to mark busy.
- flush, input, 1, clear all busy bits (pipeline squash).
- busy_vec, output, NREGS, registered busy bits, bit i = register i.

Behaviour:
- Interface: one clock (clk); asynchronous, active-high reset (rst). No other clocks or resets.
- Reset (rst=1, async): all registers = 0; all busy bits = 0. Therefore rd_data = 0, rd_busy = 0, busy_vec = 0 while rst is asserted and after release until written.
- Write, synchronous:
  - On posedge with wr_en[w]=1, reg[wr_idx[w]] <= wr_data[w]; visible on rd_data the next cycle (latency 1) when BYPASS=0.
  - Two ports writing the same index in one cycle: highest-numbered port wins; no error.
  - ZERO_REG=1: writes to index 0 are dropped.
- Read, combinational, no latency:
  - ZERO_REG=1 and rd_idx=0 -> rd_data=0, rd_busy=0.
  - BYPASS=1 and some wr_en[w] with wr_idx[w]==rd_idx[p] (excluding index 0 when ZERO_REG=1) -> rd_data[p] = wr_data of highest matching port and rd_busy[p]=0.
  - Otherwise rd_data[p] = stored value; rd_busy[p] = busy[rd_idx[p]].
- Busy bits, next state per index i, in priority order:
  1. flush=1 -> 0 (flush wins over everything, including alloc).
  2. alloc_en=1 and alloc_idx==i -> 1; alloc wins over a same-cycle write to i, because the new producer is still pending.
  3. Any wr_en[w] with wr_idx[w]==i -> 0.
  4. Otherwise hold.
  - ZERO_REG=1: busy[0] is constant 0; alloc to 0 is ignored.
- Flush does not affect register contents; writes in the flush cycle still commit.
- Writing a non-busy register is legal: data updates, busy stays 0.
- Reset mid-operation: state clears immediately and asynchronously; pending writes in that cycle are lost.
- No assertions on out-of-range indices: NREGS is a power of two, so none exist.

Decomposition:
- Shared package regfile_pkg:
  - default XLEN / NREGS constants;
  - typedef reg_idx_t (logic [AW-1:0] for the default depth);
  - typedef xword_t (logic [XLEN-1:0]).
- One natural sub-module, regfile_scoreboard: busy-bit array with alloc/clear/flush priority; outputs busy_vec.
- Read muxing, bypass and the storage array stay in regfile_mp.

Test Plan:
1. Reset then read: assert rst for 3 cycles, read idx 0..31 on all ports -> rd_data=0, rd_busy=0, busy_vec=0.
2. Basic write/read and x0: write 0xDEADBEEF to r5 on port 0; write 0x12345678 to r0. Next cycle: read r5 -> 0xDEADBEEF; read r0 -> 0.
3. Bypass and port priority (BYPASS=1): same cycle, port0 writes r7=0x1, port1 writes r7=0x2, read r7 -> 0x2 combinationally, rd_busy=0. Next cycle: stored r7=0x2. With BYPASS=0, the same-cycle read returns the old value.
4. Scoreboard:
   - alloc r9 -> busy_vec[9]=1 next cycle and read r9 rd_busy=1.
   - Write r9=0xA5 -> busy_vec[9]=0 next cycle, data 0xA5.
   - alloc r9 and write r9 in the same cycle -> busy_vec[9] stays 1.
5. Flush: alloc r3, r4, r10 over 3 cycles, then flush together with alloc r11 -> busy_vec all 0 next cycle; same-cycle write of r4=0x55 still stored.
6. Async reset mid-operation: write r12=0xFF, alloc r13, assert rst between clock edges -> r12 reads 0 and busy_vec=0 before the next clock edge.
